// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
// Consumes a byte stream (16-bit big-endian word count, then big-endian words)
// and issues one word write per instruction, holding the CPU in reset until the
// whole program has landed.
// Optional checksum trailer: define IMEM_LOADER_CHECKSUM_EN to require one extra
// byte equal to the XOR of all data bytes before the load is declared done.
// All outputs are registered and derived from the next state, so they change
// only on the clock edge (or asynchronously on reset).
module imem_loader #(
    parameter int unsigned MEM_SIZE  = 512,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_CNT_HI, S_CNT_LO, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_e;
    // After the last word the checksum byte must still be collected
    localparam state_e S_FINISH = S_CSUM;
`else
    typedef enum logic [2:0] {
        S_CNT_HI, S_CNT_LO, S_DATA, S_WRITE, S_DONE, S_ERR
    } state_e;
    localparam state_e S_FINISH = S_DONE;
`endif

    localparam logic [16:0] MEM_SIZE_W = 17'(MEM_SIZE);

    state_e      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [23:0] asm_q, asm_d;          // first three bytes of the word being built
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        ready_q, ready_d;
    logic        wr_en_q, wr_en_d;
    logic        hold_q, hold_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic        xfer;
    logic [15:0] cnt_full;

    // A byte moves only when the registered ready output is high
    assign xfer     = byte_valid && ready_q;
    assign cnt_full = {count_q[15:8], byte_data};

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        addr_d     = addr_q;
        data_d     = data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            S_CNT_HI: begin
                if (xfer) begin
                    count_d[15:8] = byte_data;
                    state_d       = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (xfer) begin
                    count_d[7:0] = byte_data;
                    byte_idx_d   = 2'd0;
                    word_idx_d   = 16'd0;
                    if (cnt_full == 16'd0)
                        state_d = S_FINISH;
                    else if ({1'b0, cnt_full} > MEM_SIZE_W)
                        state_d = S_ERR;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    asm_d      = {asm_q[15:0], byte_data};
                    byte_idx_d = byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ byte_data;
`endif
                    if (byte_idx_q == 2'd3) begin
                        data_d  = {asm_q, byte_data};
                        addr_d  = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_q + 16'd1;
                if (word_idx_q + 16'd1 == count_q)
                    state_d = S_FINISH;
                else
                    state_d = S_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (xfer)
                    state_d = (byte_data == csum_q) ? S_DONE : S_ERR;
            end
`endif
            S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_CNT_HI;
                    count_d    = 16'd0;
                    word_idx_d = 16'd0;
                    byte_idx_d = 2'd0;
                    asm_d      = 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = 8'd0;
`endif
                end
            end
            default: state_d = S_ERR;
        endcase

        // Outputs follow the state being entered so they are glitch-free flops
        ready_d = (state_d == S_CNT_HI) || (state_d == S_CNT_LO) || (state_d == S_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
        ready_d = ready_d || (state_d == S_CSUM);
`endif
        wr_en_d = (state_d == S_WRITE);
        hold_d  = (state_d != S_DONE);
        done_d  = (state_d == S_DONE);
        err_d   = (state_d == S_ERR);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_CNT_HI;
            count_q    <= 16'd0;
            word_idx_q <= 16'd0;
            byte_idx_q <= 2'd0;
            asm_q      <= 24'd0;
            addr_q     <= BASE_ADDR;
            data_q     <= 32'd0;
            ready_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            wr_en_q    <= wr_en_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign byte_ready = ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = addr_q;
    assign wr_data    = data_q;
    assign cpu_hold   = hold_q;
    assign load_done  = done_q;
    assign load_err   = err_q;

endmodule
